// File: rtl/ccip_mmio_rsp_pkg.sv
// Shared types and constants for the CCI-P MMIO read responder.
// Entry widths follow the default t_ccip_tid / t_ccip_mmioAddr sizes.
package ccip_mmio_rsp_pkg;

  localparam int MMIO_TID_W  = 9;
  localparam int MMIO_ADDR_W = 16;

  localparam logic [1:0]  MMIO_LEN_4B   = 2'b00;
  localparam logic [63:0] MMIO_ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [MMIO_TID_W-1:0]  tid;
    logic [MMIO_ADDR_W-1:0] addr;
    logic [1:0]             len;
  } t_mmio_rd_entry;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } t_mmio_rsp_state;

  // A 4B read returns the DWORD selected by the address LSB, zero-extended.
  function automatic logic [63:0] mmio_format(input logic [1:0]  len,
                                              input logic        addr_lsb,
                                              input logic [63:0] data);
    logic [63:0] result;
    result = data;
    if (len == MMIO_LEN_4B) begin
      result = {32'h0, (addr_lsb ? data[63:32] : data[31:0])};
    end
    return result;
  endfunction

endpackage

// File: rtl/ccip_mmio_rd_responder_if.sv
// MMIO read path bundle: c0 Rx request, local CSR read port, c2 Tx response, sticky errors.
interface ccip_mmio_rd_responder_if #(
  parameter int TID_W  = 9,
  parameter int ADDR_W = 16
);

  logic              rx_mmio_rd_valid;
  logic [TID_W-1:0]  rx_mmio_tid;
  logic [ADDR_W-1:0] rx_mmio_addr;
  logic [1:0]        rx_mmio_len;

  logic              csr_rd_valid;
  logic [ADDR_W-2:0] csr_rd_addr;
  logic              csr_rsp_valid;
  logic [63:0]       csr_rsp_data;

  logic              tx_mmio_rsp_valid;
  logic [TID_W-1:0]  tx_mmio_rsp_tid;
  logic [63:0]       tx_mmio_rsp_data;

  logic              overflow_err;
  logic              timeout_err;

  // The responder side.
  modport slave (
    input  rx_mmio_rd_valid, rx_mmio_tid, rx_mmio_addr, rx_mmio_len,
    input  csr_rsp_valid, csr_rsp_data,
    output csr_rd_valid, csr_rd_addr,
    output tx_mmio_rsp_valid, tx_mmio_rsp_tid, tx_mmio_rsp_data,
    output overflow_err, timeout_err
  );

  // The host / CSR-file side.
  modport master (
    output rx_mmio_rd_valid, rx_mmio_tid, rx_mmio_addr, rx_mmio_len,
    output csr_rsp_valid, csr_rsp_data,
    input  csr_rd_valid, csr_rd_addr,
    input  tx_mmio_rsp_valid, tx_mmio_rsp_tid, tx_mmio_rsp_data,
    input  overflow_err, timeout_err
  );

endinterface

// File: rtl/ccip_mmio_rd_fifo.sv
// In-order request queue: registered write, first-word-fall-through head.
// DEPTH must be a power of two; the extra pointer bit separates full from empty.
module ccip_mmio_rd_fifo
  import ccip_mmio_rsp_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  t_mmio_rd_entry push_data,
  input  logic           pop,
  output t_mmio_rd_entry head,
  output logic           full,
  output logic           empty
);

  localparam int AW = $clog2(DEPTH);

  t_mmio_rd_entry mem [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic           do_push;
  logic           do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A pop frees the slot in the same cycle, so a push onto a full queue is kept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ccip_mmio_rd_responder.sv
// AFU-side CCI-P MMIO read responder: queues host reads, serialises them onto the
// local CSR read port and returns c2 responses in arrival order with the echoed tid.
module ccip_mmio_rd_responder
  import ccip_mmio_rsp_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int TID_W          = MMIO_TID_W,
  parameter int ADDR_W         = MMIO_ADDR_W,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                      clk,
  input  logic                      reset,
  ccip_mmio_rd_responder_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  t_mmio_rd_entry  push_entry;
  t_mmio_rd_entry  head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;

  t_mmio_rsp_state   state_reg;
  logic [TW-1:0]     timer_reg;
  logic [TID_W-1:0]  cur_tid_reg;
  logic              cur_addr_lsb_reg;
  logic [1:0]        cur_len_reg;
  logic              csr_rd_valid_reg;
  logic [ADDR_W-2:0] csr_rd_addr_reg;
  logic              tx_valid_reg;
  logic [TID_W-1:0]  tx_tid_reg;
  logic [63:0]       tx_data_reg;
  logic              overflow_reg;
  logic              timeout_reg;

  assign push_entry = '{tid: bus.rx_mmio_tid, addr: bus.rx_mmio_addr, len: bus.rx_mmio_len};
  assign pop        = (state_reg == IDLE) && !fifo_empty;

  ccip_mmio_rd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.rx_mmio_rd_valid),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      timer_reg        <= '0;
      cur_tid_reg      <= '0;
      cur_addr_lsb_reg <= 1'b0;
      cur_len_reg      <= '0;
      csr_rd_valid_reg <= 1'b0;
      csr_rd_addr_reg  <= '0;
      tx_valid_reg     <= 1'b0;
      tx_tid_reg       <= '0;
      tx_data_reg      <= '0;
      overflow_reg     <= 1'b0;
      timeout_reg      <= 1'b0;
    end else begin
      csr_rd_valid_reg <= 1'b0;
      tx_valid_reg     <= 1'b0;

      // The host has no backpressure, so a request into a full, non-draining queue is lost.
      if (bus.rx_mmio_rd_valid && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            cur_tid_reg      <= head.tid;
            cur_addr_lsb_reg <= head.addr[0];
            cur_len_reg      <= head.len;
            csr_rd_valid_reg <= 1'b1;
            csr_rd_addr_reg  <= head.addr[ADDR_W-1:1];
            timer_reg        <= '0;
            state_reg        <= WAIT;
          end
        end
        WAIT: begin
          // Real data beats the timeout when both land in the same cycle.
          if (bus.csr_rsp_valid) begin
            tx_valid_reg <= 1'b1;
            tx_tid_reg   <= cur_tid_reg;
            tx_data_reg  <= mmio_format(cur_len_reg, cur_addr_lsb_reg, bus.csr_rsp_data);
            timer_reg    <= '0;
            state_reg    <= RESP;
          end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            tx_valid_reg <= 1'b1;
            tx_tid_reg   <= cur_tid_reg;
            tx_data_reg  <= MMIO_ERR_DATA;
            timeout_reg  <= 1'b1;
            timer_reg    <= '0;
            state_reg    <= RESP;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.csr_rd_valid      = csr_rd_valid_reg;
  assign bus.csr_rd_addr       = csr_rd_addr_reg;
  assign bus.tx_mmio_rsp_valid = tx_valid_reg;
  assign bus.tx_mmio_rsp_tid   = tx_tid_reg;
  assign bus.tx_mmio_rsp_data  = tx_data_reg;
  assign bus.overflow_err      = overflow_reg;
  assign bus.timeout_err       = timeout_reg;

endmodule

// File: tb/tb_ccip_mmio_rd_responder.sv
// Directed bench for ccip_mmio_rd_responder: vector table for single reads plus
// hand-written sequences for overflow, timeout, timeout/response race and mid-flight reset.
module tb_ccip_mmio_rd_responder;
  import ccip_mmio_rsp_pkg::*;

  localparam int DEPTH   = 64;
  localparam int TID_W   = 9;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 512;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ccip_mmio_rd_responder_if #(.TID_W(TID_W), .ADDR_W(ADDR_W)) bus ();

  ccip_mmio_rd_responder #(
    .DEPTH          (DEPTH),
    .TID_W          (TID_W),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR model controls (written by the test, read by the model).
  int          csr_lat     = 0;     // 0 = hold the read until a non-zero latency is set
  logic [63:0] csr_data_val = '0;
  bit          ignore_en   = 1'b0;  // never answer reads of ignore_addr
  logic [14:0] ignore_addr = '0;
  int          stray_due   = -1;    // one unsolicited csr_rsp_valid in this cycle

  // Observations (written by the model/monitor only).
  logic [14:0] rd_addr_q [$];
  int          rd_cyc_q  [$];
  logic [8:0]  tx_tid_q  [$];
  logic [63:0] tx_data_q [$];
  int          tx_cyc_q  [$];

  int n_checks = 0;
  int n_pass   = 0;

  initial begin : csr_model
    bit outstanding;
    int due;
    outstanding = 1'b0;
    due = -1;
    bus.csr_rsp_valid = 1'b0;
    bus.csr_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.tx_mmio_rsp_valid) begin
        tx_tid_q.push_back(bus.tx_mmio_rsp_tid);
        tx_data_q.push_back(bus.tx_mmio_rsp_data);
        tx_cyc_q.push_back(cyc);
      end
      if (outstanding && due == cyc) begin
        bus.csr_rsp_valid = 1'b1;
        bus.csr_rsp_data  = csr_data_val;
        outstanding = 1'b0;
      end else if (stray_due == cyc) begin
        bus.csr_rsp_valid = 1'b1;
        bus.csr_rsp_data  = 64'h5555_5555_5555_5555;
      end else begin
        bus.csr_rsp_valid = 1'b0;
      end
      if (bus.csr_rd_valid) begin
        rd_addr_q.push_back(bus.csr_rd_addr);
        rd_cyc_q.push_back(cyc);
        if (!(ignore_en && bus.csr_rd_addr == ignore_addr)) begin
          outstanding = 1'b1;
          due = (csr_lat > 0) ? cyc + csr_lat : -1;
        end
      end else if (outstanding && due < 0 && csr_lat > 0) begin
        due = cyc + csr_lat;
      end
      if (reset) outstanding = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Call aligned to a negedge; returns on the following negedge, so calls chain back-to-back.
  task automatic send(input logic [8:0] tid, input logic [15:0] addr, input logic [1:0] len,
                      output int req_cyc);
    bus.rx_mmio_tid      = tid;
    bus.rx_mmio_addr     = addr;
    bus.rx_mmio_len      = len;
    bus.rx_mmio_rd_valid = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    bus.rx_mmio_rd_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (tx_tid_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, 64'(tx_tid_q.size() >= n), 64'd1);
  endtask

  task automatic wait_rd(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rd_addr_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, 64'(rd_addr_q.size() >= n), 64'd1);
  endtask

  typedef struct {
    logic [8:0]  tid;
    logic [15:0] addr;
    logic [1:0]  len;
    int          lat;
    logic [63:0] data;
    logic [14:0] exp_rd_addr;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  initial begin : test
    int n0, r0, rq;
    vecs[0] = '{9'h005, 16'h0010, 2'b01, 3, 64'h0123_4567_89AB_CDEF, 15'h0008, 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{9'h006, 16'h0011, 2'b00, 2, 64'hAAAA_BBBB_CCCC_DDDD, 15'h0008, 64'h0000_0000_AAAA_BBBB};
    vecs[2] = '{9'h007, 16'h0010, 2'b00, 1, 64'hAAAA_BBBB_CCCC_DDDD, 15'h0008, 64'h0000_0000_CCCC_DDDD};
    vecs[3] = '{9'h1FF, 16'hFFFF, 2'b11, 5, 64'hFEDC_BA98_7654_3210, 15'h7FFF, 64'hFEDC_BA98_7654_3210};
    vecs[4] = '{9'h000, 16'h0003, 2'b10, 4, 64'h1122_3344_5566_7788, 15'h0001, 64'h1122_3344_5566_7788};
    vecs[5] = '{9'h100, 16'h8001, 2'b00, 1, 64'hDEAD_BEEF_CAFE_F00D, 15'h4000, 64'h0000_0000_DEAD_BEEF};

    bus.rx_mmio_rd_valid = 1'b0;
    bus.rx_mmio_tid      = '0;
    bus.rx_mmio_addr     = '0;
    bus.rx_mmio_len      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_csr_rd_valid", 64'(bus.csr_rd_valid), 64'd0);
    check("rst_tx_valid",     64'(bus.tx_mmio_rsp_valid), 64'd0);
    check("rst_tx_data",      bus.tx_mmio_rsp_data, 64'd0);
    check("rst_overflow",     64'(bus.overflow_err), 64'd0);
    check("rst_timeout",      64'(bus.timeout_err), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single reads from the table
    foreach (vecs[i]) begin
      n0 = tx_tid_q.size();
      r0 = rd_addr_q.size();
      csr_lat      = vecs[i].lat;
      csr_data_val = vecs[i].data;
      send(vecs[i].tid, vecs[i].addr, vecs[i].len, rq);
      wait_rd(r0 + 1, 20, $sformatf("v%0d_rd_seen", i));
      if (rd_addr_q.size() > r0) begin
        check($sformatf("v%0d_rd_addr", i), 64'(rd_addr_q[r0]), 64'(vecs[i].exp_rd_addr));
        check($sformatf("v%0d_rd_latency", i), 64'(rd_cyc_q[r0] - rq), 64'd2);
      end
      wait_tx(n0 + 1, 40, $sformatf("v%0d_tx_seen", i));
      if (tx_tid_q.size() > n0 && rd_cyc_q.size() > r0) begin
        check($sformatf("v%0d_tx_tid", i),  64'(tx_tid_q[n0]), 64'(vecs[i].tid));
        check($sformatf("v%0d_tx_data", i), tx_data_q[n0], vecs[i].exp_data);
        check($sformatf("v%0d_tx_latency", i), 64'(tx_cyc_q[n0] - rd_cyc_q[r0]), 64'(vecs[i].lat + 1));
      end
      repeat (3) @(negedge clk);
    end

    // CSR response lands on the exact timeout cycle: real data, no flag
    n0 = tx_tid_q.size();
    r0 = rd_addr_q.size();
    csr_lat      = TIMEOUT - 1;
    csr_data_val = 64'h0F0E_0D0C_0B0A_0908;
    send(9'h02A, 16'h0040, 2'b01, rq);
    wait_tx(n0 + 1, TIMEOUT + 20, "race_tx_seen");
    if (tx_tid_q.size() > n0 && rd_cyc_q.size() > r0) begin
      check("race_tx_tid",     64'(tx_tid_q[n0]), 64'h02A);
      check("race_tx_data",    tx_data_q[n0], 64'h0F0E_0D0C_0B0A_0908);
      check("race_tx_latency", 64'(tx_cyc_q[n0] - rd_cyc_q[r0]), 64'(TIMEOUT));
    end
    repeat (2) @(negedge clk);
    check("race_timeout_err", 64'(bus.timeout_err), 64'd0);

    // DEPTH+1 burst while one read is held in WAIT: last request dropped
    n0 = tx_tid_q.size();
    r0 = rd_addr_q.size();
    csr_lat      = 0;
    csr_data_val = 64'h0000_0000_1234_5678;
    @(negedge clk);
    send(9'h040, 16'h0100, 2'b01, rq);
    wait_rd(r0 + 1, 20, "burst_head_rd_seen");
    @(negedge clk);
    for (int i = 0; i <= DEPTH; i++) begin
      send(9'(9'h080 + i), 16'(16'h0200 + 2 * i), 2'b01, rq);
      if (i == DEPTH - 1) check("burst_not_yet_overflow", 64'(bus.overflow_err), 64'd0);
    end
    check("burst_overflow_err", 64'(bus.overflow_err), 64'd1);
    csr_lat = 1;
    wait_tx(n0 + DEPTH + 1, 2000, "burst_all_tx_seen");
    repeat (40) @(negedge clk);
    check("burst_tx_count", 64'(tx_tid_q.size() - n0), 64'(DEPTH + 1));
    if (tx_tid_q.size() >= n0 + DEPTH + 1) begin
      check("burst_tid_head", 64'(tx_tid_q[n0]), 64'h040);
      for (int i = 0; i < DEPTH; i++) begin
        check($sformatf("burst_tid_%0d", i), 64'(tx_tid_q[n0 + 1 + i]), 64'(9'h080 + i));
      end
    end
    check("burst_timeout_err", 64'(bus.timeout_err), 64'd0);

    // Reset while WAIT holds one read and three more are queued
    r0 = rd_addr_q.size();
    csr_lat = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(9'(9'h010 + i), 16'(16'h0400 + 2 * i), 2'b01, rq);
    wait_rd(r0 + 1, 20, "rst_mid_rd_seen");
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_csr_rd_valid", 64'(bus.csr_rd_valid), 64'd0);
    check("rst_mid_tx_valid",     64'(bus.tx_mmio_rsp_valid), 64'd0);
    check("rst_mid_overflow",     64'(bus.overflow_err), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n0 = tx_tid_q.size();
    r0 = rd_addr_q.size();
    stray_due = cyc + 2;
    repeat (6) @(negedge clk);
    csr_lat      = 2;
    csr_data_val = 64'h7777_6666_5555_4444;
    send(9'h077, 16'h0300, 2'b00, rq);
    wait_tx(n0 + 1, 100, "rst_new_tx_seen");
    repeat (30) @(negedge clk);
    check("rst_tx_count", 64'(tx_tid_q.size() - n0), 64'd1);
    check("rst_rd_count", 64'(rd_addr_q.size() - r0), 64'd1);
    if (tx_tid_q.size() > n0) begin
      check("rst_new_tid",  64'(tx_tid_q[n0]), 64'h077);
      check("rst_new_data", tx_data_q[n0], 64'h0000_0000_5555_4444);
    end

    // CSR never answers the first read; the second is serviced normally
    n0 = tx_tid_q.size();
    r0 = rd_addr_q.size();
    ignore_en    = 1'b1;
    ignore_addr  = 15'h0100;
    csr_lat      = 2;
    csr_data_val = 64'h89AB_CDEF_0246_8ACE;
    send(9'h033, 16'h0200, 2'b01, rq);
    send(9'h034, 16'h0202, 2'b00, rq);
    wait_tx(n0 + 1, TIMEOUT + 40, "to_tx_seen");
    if (tx_tid_q.size() > n0 && rd_cyc_q.size() > r0) begin
      check("to_tx_tid",     64'(tx_tid_q[n0]), 64'h033);
      check("to_tx_data",    tx_data_q[n0], MMIO_ERR_DATA);
      check("to_tx_latency", 64'(tx_cyc_q[n0] - rd_cyc_q[r0]), 64'(TIMEOUT));
    end
    @(negedge clk);
    check("to_timeout_err", 64'(bus.timeout_err), 64'd1);
    wait_tx(n0 + 2, 40, "to_next_tx_seen");
    if (tx_tid_q.size() > n0 + 1) begin
      check("to_next_tid",  64'(tx_tid_q[n0 + 1]), 64'h034);
      check("to_next_data", tx_data_q[n0 + 1], 64'h0000_0000_0246_8ACE);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
